// File: rtl/fetch_unit.sv
// IF stage: in-order imem fetch into a small response queue, feeding the IF/ID register.
// Fetch latency gnt->rvalid->queue->IF/ID is 3 cycles; keep holds IF/ID while the queue fills up to its credit.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        keep,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        branch_PC_early_contral,
    input  logic [31:0] branch_PC_early,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_pype0,
    output logic [31:0] PCp4_pype0,
    output logic [31:0] Instraction_pype,
    output logic        if_bubble
);
    localparam int             PW      = $clog2(FQ_DEPTH);
    localparam int             CW      = PW + 1;
    localparam logic [CW:0]    L_DEPTH = (CW+1)'(FQ_DEPTH);

    logic [31:0]   r_fpc;
    logic [31:0]   r_rpc;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_drop;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [31:0]   r_q_pc   [FQ_DEPTH];
    logic [31:0]   r_q_inst [FQ_DEPTH];

    logic          w_redirect;
    logic [31:0]   w_target;
    logic          w_pop;
    logic          w_push;
    logic          w_gnt;
    logic          w_drop;
    logic [CW:0]   w_used;
    logic [CW-1:0] w_outst_nxt;

    assign w_redirect = flush | branch_PC_early_contral;
    assign w_target   = flush ? flush_pc : branch_PC_early;
    assign w_pop      = !w_redirect && !keep && (r_cnt != '0);

    // The slot being popped this cycle is already free, so back-to-back fetch
    // sustains one instruction per cycle with only two credits.
    assign w_used    = {1'b0, r_outst} + {1'b0, r_cnt} - (CW+1)'(w_pop);
    assign imem_req  = rst && (w_used < L_DEPTH);
    assign imem_addr = r_fpc;

    assign w_gnt       = imem_req && imem_gnt;
    assign w_drop      = imem_rvalid && (r_drop != '0);
    assign w_push      = imem_rvalid && (r_drop == '0) && !w_redirect;
    assign w_outst_nxt = r_outst + CW'(w_gnt) - CW'(imem_rvalid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fpc            <= RESET_PC;
            r_rpc            <= RESET_PC;
            r_outst          <= '0;
            r_cnt            <= '0;
            r_drop           <= '0;
            r_wptr           <= '0;
            r_rptr           <= '0;
            PC_pype0         <= '0;
            PCp4_pype0       <= '0;
            Instraction_pype <= NOP_INST;
            if_bubble        <= 1'b1;
        end else begin
            r_outst <= w_outst_nxt;
            if (w_redirect) begin
                // Everything still in flight after this cycle belongs to the old path.
                r_fpc  <= w_target;
                r_rpc  <= w_target;
                r_drop <= w_outst_nxt;
                r_cnt  <= '0;
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_gnt)  r_fpc  <= r_fpc + 32'd4;
                if (w_drop) r_drop <= r_drop - CW'(1);
                if (w_push) begin
                    r_rpc  <= r_rpc + 32'd4;
                    r_wptr <= r_wptr + PW'(1);
                end
                if (w_pop)  r_rptr <= r_rptr + PW'(1);
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end

            if (w_redirect || (!keep && r_cnt == '0)) begin
                PC_pype0         <= '0;
                PCp4_pype0       <= '0;
                Instraction_pype <= NOP_INST;
                if_bubble        <= 1'b1;
            end else if (w_pop) begin
                PC_pype0         <= r_q_pc[r_rptr];
                PCp4_pype0       <= r_q_pc[r_rptr] + 32'd4;
                Instraction_pype <= r_q_inst[r_rptr];
                if_bubble        <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wptr]   <= r_rpc;
            r_q_inst[r_wptr] <= imem_rdata;
        end
    end

    a_rvalid_has_owner: assert property (@(posedge clk) disable iff (!rst)
        imem_rvalid |-> (r_outst != '0));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] OFS = 32'h1000_0000;

    logic        clk;
    logic        rst;
    logic        keep, flush, br;
    logic [31:0] flush_pc, br_pc;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] PC_pype0, PCp4_pype0, Instraction_pype;
    logic        if_bubble;
    logic        req2, rvalid2, bub2;
    logic [31:0] addr2, rdata2, pc2, pcp42, inst2;

    logic        rsp_en, gnt_en;
    logic [31:0] mq[$];
    logic        pend2;
    logic [31:0] pend2_addr;
    logic        req_s, req2_s;
    logic [31:0] addr_s, addr2_s;

    int n_chk = 0;
    int n_bad = 0;

    fetch_unit u_dut (
        .clk(clk), .rst(rst), .keep(keep), .flush(flush), .flush_pc(flush_pc),
        .branch_PC_early_contral(br), .branch_PC_early(br_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .PC_pype0(PC_pype0), .PCp4_pype0(PCp4_pype0),
        .Instraction_pype(Instraction_pype), .if_bubble(if_bubble)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .rst(rst), .keep(keep), .flush(flush), .flush_pc(flush_pc),
        .branch_PC_early_contral(br), .branch_PC_early(br_pc),
        .imem_req(req2), .imem_addr(addr2), .imem_gnt(imem_gnt),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .PC_pype0(pc2), .PCp4_pype0(pcp42),
        .Instraction_pype(inst2), .if_bubble(bub2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc);
        chk({tag, ".pc"},   PC_pype0, pc);
        chk({tag, ".pcp4"}, PCp4_pype0, pc + 32'd4);
        chk({tag, ".inst"}, Instraction_pype, pc + OFS);
        chk({tag, ".bub"},  32'(if_bubble), 32'd0);
    endtask

    task automatic chk_bub(input string tag);
        chk({tag, ".pc"},   PC_pype0, 32'd0);
        chk({tag, ".pcp4"}, PCp4_pype0, 32'd0);
        chk({tag, ".inst"}, Instraction_pype, NOP);
        chk({tag, ".bub"},  32'(if_bubble), 32'd1);
    endtask

    // One clock: present memory responses, sample the request side, cross the edge.
    task automatic tick();
        logic        hs, hs2;
        logic [31:0] a, a2;
        if (rsp_en && mq.size() != 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mq.pop_front() + OFS;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        rvalid2  = pend2;
        rdata2   = pend2_addr + OFS;
        imem_gnt = gnt_en;
        #1;
        req_s   = imem_req;
        addr_s  = imem_addr;
        req2_s  = req2;
        addr2_s = addr2;
        hs  = imem_req && imem_gnt;
        hs2 = req2 && imem_gnt;
        a   = imem_addr;
        a2  = addr2;
        @(posedge clk);
        #1;
        if (hs) mq.push_back(a);
        pend2      = hs2;
        pend2_addr = a2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        keep = 1'b0; flush = 1'b0; br = 1'b0;
        flush_pc = '0; br_pc = '0;
        rsp_en = 1'b1; gnt_en = 1'b1;
        imem_rvalid = 1'b0; imem_rdata = '0; imem_gnt = 1'b0;
        rvalid2 = 1'b0; rdata2 = '0;
        mq.delete();
        pend2 = 1'b0; pend2_addr = '0;
        @(posedge clk);
        #1;
        chk_bub("rst");
        chk("rst.req",  32'(imem_req), 32'd0);
        chk("rst.req2", 32'(req2), 32'd0);
        chk("rst.bub2", 32'(bub2), 32'd1);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        #1;
        do_reset();

        // Sequential fetch from 0 plus the wrapping instance.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("A.req%0d", i),   32'(req_s), 32'd1);
            chk($sformatf("A.addr%0d", i),  addr_s, 32'(4 * i));
            chk($sformatf("W.addr%0d", i),  addr2_s, 32'hFFFF_FFF8 + 32'(4 * i));
            if (i >= 2) begin
                chk_ifid($sformatf("A.if%0d", i), 32'(4 * (i - 2)));
                chk($sformatf("W.pc%0d", i),   pc2, 32'hFFFF_FFF8 + 32'(4 * (i - 2)));
                chk($sformatf("W.pcp4%0d", i), pcp42, 32'hFFFF_FFFC + 32'(4 * (i - 2)));
                chk($sformatf("W.bub%0d", i),  32'(bub2), 32'd0);
            end else begin
                chk_bub($sformatf("A.if%0d", i));
            end
        end

        // Decode stall while IF/ID holds PC 8.
        keep = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("K.req%0d", i), 32'(req_s), 32'd0);
            chk_ifid($sformatf("K.hold%0d", i), 32'd8);
        end
        keep = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_ifid($sformatf("K.res%0d", i), 32'd12 + 32'(4 * i));
        end

        // Early branch with two requests in flight.
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        chk_ifid("B.pre0", 32'd0);
        rsp_en = 1'b0;
        tick();
        chk_ifid("B.pre1", 32'd4);
        rsp_en = 1'b1; br = 1'b1; br_pc = 32'h100;
        tick();
        chk("B.req_redir", 32'(req_s), 32'd0);
        chk_bub("B.bub0");
        br = 1'b0; br_pc = '0;
        tick();
        chk("B.req", 32'(req_s), 32'd1);
        chk("B.addr0", addr_s, 32'h100);
        chk_bub("B.bub1");
        tick();
        chk("B.addr1", addr_s, 32'h104);
        chk_bub("B.bub2");
        tick();
        chk_ifid("B.if0", 32'h100);
        tick();
        chk_ifid("B.if1", 32'h104);

        // Flush, early branch and keep together: flush wins.
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        chk_ifid("C.pre", 32'd4);
        flush = 1'b1; flush_pc = 32'h200; keep = 1'b1; br = 1'b1; br_pc = 32'h300;
        tick();
        chk("C.req_redir", 32'(req_s), 32'd0);
        chk_bub("C.bub");
        flush = 1'b0; keep = 1'b0; br = 1'b0;
        tick();
        chk("C.req", 32'(req_s), 32'd1);
        chk("C.addr0", addr_s, 32'h200);
        tick();
        chk("C.addr1", addr_s, 32'h204);
        tick();
        chk_ifid("C.if0", 32'h200);

        // Grant withheld for four cycles at 0x40.
        do_reset();
        for (int i = 0; i < 16; i++) tick();
        chk_ifid("D.pre", 32'h34);
        gnt_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("D.req%0d", i),  32'(req_s), 32'd1);
            chk($sformatf("D.addr%0d", i), addr_s, 32'h40);
            if (i < 2) chk_ifid($sformatf("D.drain%0d", i), 32'h38 + 32'(4 * i));
            else       chk_bub($sformatf("D.empty%0d", i));
        end
        gnt_en = 1'b1;
        tick();
        chk("D.addr_go", addr_s, 32'h40);
        tick();
        chk("D.addr_nx", addr_s, 32'h44);
        chk_bub("D.bub");
        tick();
        chk_ifid("D.if0", 32'h40);
        tick();
        chk_ifid("D.if1", 32'h44);

        // Reset with requests outstanding.
        do_reset();
        tick();
        chk("R.addr", addr_s, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
